// File: rtl/frame_pkg.sv
// +--------------------------------------------------------------------------+
// | Module   : frame_pkg                                                     |
// | Purpose  : shared state encoding, word/pixel defaults and the row-stride |
// |            helper used by the frame_streamer slice.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package frame_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      CAPTURE = 3'd2,
      PRESENT = 3'd3,
      HBLANK  = 3'd4,
      VBLANK  = 3'd5,
      DONE    = 3'd6
   } state_t;

   localparam int DEF_WORD_SIZE       = 8;
   localparam int DEF_BYTES_PER_PIXEL = 3;
   localparam int DEF_PIXEL_SIZE      = DEF_WORD_SIZE * DEF_BYTES_PER_PIXEL;

   // Bytes per row; bpp is 1..4 so shift-and-add replaces a real multiplier.
   // With pad set the row is rounded up to the next 4-byte boundary (BMP rows).
   function automatic logic [31:0] row_stride(input logic [31:0] width,
                                              input logic [2:0]  bpp,
                                              input logic        pad);
      logic [31:0] raw;
      case (bpp)
         3'd1:    raw = width;
         3'd2:    raw = width << 1;
         3'd3:    raw = (width << 1) + width;
         default: raw = width << 2;
      endcase
      if (pad) begin
         raw = (raw + 32'd3) & ~32'd3;
      end
      return raw;
   endfunction

endpackage

`default_nettype wire

// File: rtl/frame_streamer_if.sv
// +--------------------------------------------------------------------------+
// | Module   : frame_streamer_if                                             |
// | Purpose  : memory read port plus pixel stream (valid/ready, syncs).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

interface frame_streamer_if #(
   parameter int WORD_SIZE       = 8,
   parameter int BYTES_PER_PIXEL = 3,
   parameter int ADDR_WIDTH      = 20
);
   localparam int PIXEL_SIZE = WORD_SIZE * BYTES_PER_PIXEL;

   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [WORD_SIZE-1:0]  rd_data;

   logic                  pix_valid;
   logic                  pix_ready;
   logic [PIXEL_SIZE-1:0] pix_data;
   logic                  hsync;
   logic                  vsync;

   modport master (
      output rd_en, rd_addr,
      input  rd_data,
      output pix_valid, pix_data, hsync, vsync,
      input  pix_ready
   );

   modport slave (
      input  rd_en, rd_addr,
      output rd_data,
      input  pix_valid, pix_data, hsync, vsync,
      output pix_ready
   );

endinterface

`default_nettype wire

// File: rtl/frame_streamer_byte_packer.sv
// +--------------------------------------------------------------------------+
// | Module   : byte_packer                                                   |
// | Purpose  : assembles BYTES_PER_PIXEL words into one pixel; word k lands  |
// |            in bits [k*WORD_SIZE +: WORD_SIZE].                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module byte_packer #(
   parameter int WORD_SIZE       = 8,
   parameter int BYTES_PER_PIXEL = 3
) (
   input  wire logic                                 clk,
   input  wire logic                                 clear,
   input  wire logic                                 load,
   input  wire logic [1:0]                           load_idx,
   input  wire logic [WORD_SIZE-1:0]                 din,
   output logic [WORD_SIZE*BYTES_PER_PIXEL-1:0]      data
);

   localparam int PIXEL_SIZE = WORD_SIZE * BYTES_PER_PIXEL;

   logic [PIXEL_SIZE-1:0] data_q;
   logic [PIXEL_SIZE-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (clear) begin
         data_d = '0;
      end else if (load) begin
         for (int k = 0; k < BYTES_PER_PIXEL; k++) begin
            if (load_idx == 2'(k)) begin
               data_d[k*WORD_SIZE +: WORD_SIZE] = din;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign data = data_q;

endmodule

`default_nettype wire

// File: rtl/frame_streamer.sv
// +--------------------------------------------------------------------------+
// | Module   : frame_streamer                                                |
// | Purpose  : walks a byte-addressed frame buffer and emits a pixel stream  |
// |            with hsync/vsync, blanking, backpressure and done pulse.      |
// |            Define FRAME_STREAMER_ROW_PAD_EN for 4-byte BMP row padding.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module frame_streamer
   import frame_pkg::*;
#(
   parameter int WORD_SIZE       = DEF_WORD_SIZE,
   parameter int BYTES_PER_PIXEL = DEF_BYTES_PER_PIXEL,
   parameter int ADDR_WIDTH      = 20,
   parameter int DIM_WIDTH       = 12,
   parameter int H_BLANK         = 0,
   parameter int V_BLANK         = 0
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   input  wire logic                  start,
   input  wire logic [DIM_WIDTH-1:0]  width,
   input  wire logic [DIM_WIDTH-1:0]  height,
   input  wire logic [ADDR_WIDTH-1:0] base_addr,
   frame_streamer_if.master           bus,
   output logic                       busy,
   output logic                       done
);

   localparam int PIXEL_SIZE  = WORD_SIZE * BYTES_PER_PIXEL;
   localparam int BLANK_WIDTH = 16;
`ifdef FRAME_STREAMER_ROW_PAD_EN
   localparam logic ROW_PAD = 1'b1;
`else
   localparam logic ROW_PAD = 1'b0;
`endif
   localparam logic [1:0]            LAST_BYTE = 2'(BYTES_PER_PIXEL - 1);
   localparam logic [ADDR_WIDTH-1:0] PIX_STEP  = ADDR_WIDTH'(BYTES_PER_PIXEL);

   state_t                 state_q,     state_d;
   logic [DIM_WIDTH-1:0]   width_q,     width_d;
   logic [DIM_WIDTH-1:0]   height_q,    height_d;
   logic [DIM_WIDTH-1:0]   col_q,       col_d;
   logic [DIM_WIDTH-1:0]   row_q,       row_d;
   logic [ADDR_WIDTH-1:0]  stride_q,    stride_d;
   logic [ADDR_WIDTH-1:0]  pix_addr_q,  pix_addr_d;
   logic [ADDR_WIDTH-1:0]  row_addr_q,  row_addr_d;
   logic [1:0]             byte_idx_q,  byte_idx_d;
   logic [BLANK_WIDTH-1:0] blank_q,     blank_d;
   logic                   rd_en_q,     rd_en_d;
   logic [ADDR_WIDTH-1:0]  rd_addr_q,   rd_addr_d;
   logic                   ld_q,        ld_d;
   logic [1:0]             ld_idx_q,    ld_idx_d;
   logic                   pix_valid_q, pix_valid_d;
   logic                   hsync_q,     hsync_d;
   logic                   vsync_q,     vsync_d;
   logic                   busy_q,      busy_d;
   logic                   done_q,      done_d;

   logic                   accept;
   logic                   fetch_go;
   logic [ADDR_WIDTH-1:0]  fetch_addr;
   logic [ADDR_WIDTH-1:0]  next_pix_addr;
   logic [ADDR_WIDTH-1:0]  next_row_addr;
   logic [PIXEL_SIZE-1:0]  packed_pixel;

   assign next_pix_addr = pix_addr_q + PIX_STEP;
   assign next_row_addr = row_addr_q + stride_q;

   always_comb begin
      state_d     = state_q;
      width_d     = width_q;
      height_d    = height_q;
      col_d       = col_q;
      row_d       = row_q;
      stride_d    = stride_q;
      pix_addr_d  = pix_addr_q;
      row_addr_d  = row_addr_q;
      byte_idx_d  = byte_idx_q;
      blank_d     = blank_q;
      rd_en_d     = rd_en_q;
      rd_addr_d   = rd_addr_q;
      ld_d        = rd_en_q;
      ld_idx_d    = byte_idx_q;
      pix_valid_d = pix_valid_q;
      hsync_d     = hsync_q;
      vsync_d     = vsync_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      accept      = 1'b0;
      fetch_go    = 1'b0;
      fetch_addr  = pix_addr_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               busy_d     = 1'b1;
               width_d    = width;
               height_d   = height;
               col_d      = '0;
               row_d      = '0;
               pix_addr_d = base_addr;
               row_addr_d = base_addr;
               stride_d   = ADDR_WIDTH'(row_stride(32'(width), 3'(BYTES_PER_PIXEL), ROW_PAD));
               if ((width == '0) || (height == '0)) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  fetch_go   = 1'b1;
                  fetch_addr = base_addr;
               end
            end
         end
         FETCH: begin
            if (byte_idx_q == LAST_BYTE) begin
               rd_en_d = 1'b0;
               state_d = CAPTURE;
            end else begin
               byte_idx_d = byte_idx_q + 2'd1;
               rd_addr_d  = rd_addr_q + ADDR_WIDTH'(1);
            end
         end
         CAPTURE: begin
            state_d     = PRESENT;
            pix_valid_d = 1'b1;
            hsync_d     = (col_q == '0);
            vsync_d     = (col_q == '0) && (row_q == '0);
         end
         PRESENT: begin
            if (bus.pix_ready) begin
               pix_valid_d = 1'b0;
               hsync_d     = 1'b0;
               vsync_d     = 1'b0;
               if (col_q != width_q - DIM_WIDTH'(1)) begin
                  col_d      = col_q + DIM_WIDTH'(1);
                  pix_addr_d = next_pix_addr;
                  fetch_go   = 1'b1;
                  fetch_addr = next_pix_addr;
               end else if (row_q != height_q - DIM_WIDTH'(1)) begin
                  // Next row starts from the running row base, never from the last pixel.
                  col_d      = '0;
                  row_d      = row_q + DIM_WIDTH'(1);
                  row_addr_d = next_row_addr;
                  pix_addr_d = next_row_addr;
                  if (H_BLANK == 0) begin
                     fetch_go   = 1'b1;
                     fetch_addr = next_row_addr;
                  end else begin
                     state_d = HBLANK;
                     blank_d = '0;
                  end
               end else if (V_BLANK == 0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = VBLANK;
                  blank_d = '0;
               end
            end
         end
         HBLANK: begin
            if (blank_q == BLANK_WIDTH'(H_BLANK - 1)) begin
               fetch_go   = 1'b1;
               fetch_addr = pix_addr_q;
            end else begin
               blank_d = blank_q + BLANK_WIDTH'(1);
            end
         end
         VBLANK: begin
            if (blank_q == BLANK_WIDTH'(V_BLANK - 1)) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               blank_d = blank_q + BLANK_WIDTH'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (fetch_go) begin
         state_d    = FETCH;
         rd_en_d    = 1'b1;
         rd_addr_d  = fetch_addr;
         byte_idx_d = 2'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         width_q     <= '0;
         height_q    <= '0;
         col_q       <= '0;
         row_q       <= '0;
         stride_q    <= '0;
         pix_addr_q  <= '0;
         row_addr_q  <= '0;
         byte_idx_q  <= '0;
         blank_q     <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         ld_q        <= 1'b0;
         ld_idx_q    <= '0;
         pix_valid_q <= 1'b0;
         hsync_q     <= 1'b0;
         vsync_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         width_q     <= width_d;
         height_q    <= height_d;
         col_q       <= col_d;
         row_q       <= row_d;
         stride_q    <= stride_d;
         pix_addr_q  <= pix_addr_d;
         row_addr_q  <= row_addr_d;
         byte_idx_q  <= byte_idx_d;
         blank_q     <= blank_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         ld_q        <= ld_d;
         ld_idx_q    <= ld_idx_d;
         pix_valid_q <= pix_valid_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Loads trail rd_en by one cycle to match the memory's read latency.
   byte_packer #(
      .WORD_SIZE       (WORD_SIZE),
      .BYTES_PER_PIXEL (BYTES_PER_PIXEL)
   ) u_byte_packer (
      .clk      (clk),
      .clear    (reset || accept),
      .load     (ld_q),
      .load_idx (ld_idx_q),
      .din      (bus.rd_data),
      .data     (packed_pixel)
   );

   assign bus.rd_en     = rd_en_q;
   assign bus.rd_addr   = rd_addr_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.pix_data  = packed_pixel;
   assign bus.hsync     = hsync_q;
   assign bus.vsync     = vsync_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_streamer.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_frame_streamer                                             |
// | Purpose  : directed, table-driven checks of frame_streamer; expected     |
// |            values follow FRAME_STREAMER_ROW_PAD_EN when it is defined.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_frame_streamer;

`ifdef FRAME_STREAMER_ROW_PAD_EN
   localparam logic [23:0] R0_LAST  = 24'h0D0C0B;
   localparam logic [19:0] R0_ALAST = 20'h0010D;
   localparam logic [19:0] R0_ROW1  = 20'h00108;
   localparam logic [23:0] R0_P2    = 24'h0A0908;
   localparam logic [23:0] R3_LAST  = 24'h2A2928;
   localparam logic [19:0] R3_ALAST = 20'h0002A;
   localparam logic [19:0] R3_ROW1  = 20'h00024;
   localparam logic [23:0] R4_LAST  = 24'h1E1D1C;
   localparam logic [19:0] R4_ALAST = 20'h0001E;
   localparam logic [19:0] R4_ROW1  = 20'h00010;
   localparam logic [15:0] B_PIX1   = 16'h4544;
   localparam logic [19:0] B_ROW1   = 20'h00044;
`else
   localparam logic [23:0] R0_LAST  = 24'h0B0A09;
   localparam logic [19:0] R0_ALAST = 20'h0010B;
   localparam logic [19:0] R0_ROW1  = 20'h00106;
   localparam logic [23:0] R0_P2    = 24'h080706;
   localparam logic [23:0] R3_LAST  = 24'h282726;
   localparam logic [19:0] R3_ALAST = 20'h00028;
   localparam logic [19:0] R3_ROW1  = 20'h00023;
   localparam logic [23:0] R4_LAST  = 24'h1D1C1B;
   localparam logic [19:0] R4_ALAST = 20'h0001D;
   localparam logic [19:0] R4_ROW1  = 20'h0000F;
   localparam logic [15:0] B_PIX1   = 16'h4342;
   localparam logic [19:0] B_ROW1   = 20'h00042;
`endif

   logic        clk = 1'b0;
   logic        reset;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   frame_streamer_if #(.WORD_SIZE(8), .BYTES_PER_PIXEL(3), .ADDR_WIDTH(20)) if0 ();
   frame_streamer_if #(.WORD_SIZE(8), .BYTES_PER_PIXEL(2), .ADDR_WIDTH(20)) if1 ();

   logic        s0_start, s0_busy, s0_done;
   logic [11:0] s0_w, s0_h;
   logic [19:0] s0_base;
   logic        s1_start, s1_busy, s1_done;
   logic [11:0] s1_w, s1_h;
   logic [19:0] s1_base;

   frame_streamer #(
      .WORD_SIZE(8), .BYTES_PER_PIXEL(3), .ADDR_WIDTH(20), .DIM_WIDTH(12),
      .H_BLANK(0), .V_BLANK(0)
   ) u_dut0 (
      .clk(clk), .reset(reset), .start(s0_start), .width(s0_w), .height(s0_h),
      .base_addr(s0_base), .bus(if0), .busy(s0_busy), .done(s0_done)
   );

   frame_streamer #(
      .WORD_SIZE(8), .BYTES_PER_PIXEL(2), .ADDR_WIDTH(20), .DIM_WIDTH(12),
      .H_BLANK(4), .V_BLANK(2)
   ) u_dut1 (
      .clk(clk), .reset(reset), .start(s1_start), .width(s1_w), .height(s1_h),
      .base_addr(s1_base), .bus(if1), .busy(s1_busy), .done(s1_done)
   );

   // Memory content is the low address byte, one-cycle read latency.
   always @(posedge clk) begin
      if (if0.rd_en) if0.rd_data <= if0.rd_addr[7:0];
      if (if1.rd_en) if1.rd_data <= if1.rd_addr[7:0];
   end

   logic [19:0] rd_log0[$];
   logic [23:0] px_log0[$];
   logic        hs_log0[$];
   logic        vs_log0[$];
   int unsigned hs_cyc0[$];
   int          done_cnt0;
   int unsigned done_cyc0, first_valid0, acc0;
   bit          seen_valid0;

   logic [19:0] rd_log1[$];
   int unsigned rd_cyc1[$];
   logic [15:0] px_log1[$];
   logic        hs_log1[$];
   logic        vs_log1[$];
   int unsigned hs_cyc1[$];
   int          done_cnt1;
   int unsigned done_cyc1, first_valid1, acc1;
   bit          seen_valid1;

   always @(negedge clk) begin
      if (if0.rd_en) rd_log0.push_back(if0.rd_addr);
      if (if0.pix_valid && !seen_valid0) begin seen_valid0 = 1'b1; first_valid0 = cyc; end
      if (if0.pix_valid && if0.pix_ready) begin
         px_log0.push_back(if0.pix_data); hs_log0.push_back(if0.hsync);
         vs_log0.push_back(if0.vsync); hs_cyc0.push_back(cyc);
      end
      if (s0_done) begin done_cnt0++; done_cyc0 = cyc; end

      if (if1.rd_en) begin rd_log1.push_back(if1.rd_addr); rd_cyc1.push_back(cyc); end
      if (if1.pix_valid && !seen_valid1) begin seen_valid1 = 1'b1; first_valid1 = cyc; end
      if (if1.pix_valid && if1.pix_ready) begin
         px_log1.push_back(if1.pix_data); hs_log1.push_back(if1.hsync);
         vs_log1.push_back(if1.vsync); hs_cyc1.push_back(cyc);
      end
      if (s1_done) begin done_cnt1++; done_cyc1 = cyc; end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log0();
      rd_log0.delete(); px_log0.delete(); hs_log0.delete(); vs_log0.delete(); hs_cyc0.delete();
      done_cnt0 = 0; seen_valid0 = 1'b0;
   endtask

   task automatic start0(input int w, input int h, input logic [19:0] base);
      clear_log0();
      s0_w = 12'(w); s0_h = 12'(h); s0_base = base;
      s0_start = 1'b1; acc0 = cyc;
      tick();
      s0_start = 1'b0;
   endtask

   task automatic wait_done0();
      for (int i = 0; i < 3000 && done_cnt0 == 0; i++) tick();
      repeat (4) tick();
      check("done_pulses", done_cnt0, 1);
      check("busy_idle", s0_busy, 0);
   endtask

   task automatic run0(input int w, input int h, input logic [19:0] base);
      start0(w, h, base);
      @(negedge clk);
      check("busy_after_start", s0_busy, 1);
      wait_done0();
   endtask

   typedef struct {
      int          w;
      int          h;
      logic [19:0] base;
      int          n_pix;
      logic [23:0] pix_first;
      logic [23:0] pix_last;
      logic [19:0] addr_last;
      logic [19:0] addr_row1;
      int          n_hs;
   } run_vec_t;

   typedef struct {
      logic [23:0] d;
      logic        hs;
      logic        vs;
   } pix_vec_t;

   run_vec_t runs[6];
   pix_vec_t pv[4];

   initial begin
      logic [23:0] cap_d;
      logic        cap_hs, cap_vs;
      int          rd_snap, cnt_hs, cnt_vs;

      runs[0] = '{2, 2, 20'h00100, 4,  24'h020100, R0_LAST,     R0_ALAST,  R0_ROW1,   2};
      runs[1] = '{0, 5, 20'h00200, 0,  24'h0,      24'h0,       20'h0,     20'h0,     0};
      runs[2] = '{3, 1, 20'hFFFFD, 3,  24'hFFFEFD, 24'h050403,  20'h00005, 20'h0,     1};
      runs[3] = '{1, 3, 20'h00020, 3,  24'h222120, R3_LAST,     R3_ALAST,  R3_ROW1,   3};
      runs[4] = '{5, 2, 20'h00000, 10, 24'h020100, R4_LAST,     R4_ALAST,  R4_ROW1,   2};
      runs[5] = '{3, 0, 20'h00300, 0,  24'h0,      24'h0,       20'h0,     20'h0,     0};
      pv[0] = '{24'h020100, 1'b1, 1'b1};
      pv[1] = '{24'h050403, 1'b0, 1'b0};
      pv[2] = '{R0_P2,      1'b1, 1'b0};
      pv[3] = '{R0_LAST,    1'b0, 1'b0};

      reset = 1'b1;
      s0_start = 1'b0; s0_w = '0; s0_h = '0; s0_base = '0;
      s1_start = 1'b0; s1_w = '0; s1_h = '0; s1_base = '0;
      if0.pix_ready = 1'b1; if1.pix_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("rst_rd_en",     if0.rd_en,     0);
      check("rst_rd_addr",   if0.rd_addr,   0);
      check("rst_pix_valid", if0.pix_valid, 0);
      check("rst_pix_data",  if0.pix_data,  0);
      check("rst_sync",      {if0.hsync, if0.vsync}, 0);
      check("rst_busy_done", {s0_busy, s0_done, s1_busy, s1_done}, 0);
      tick();
      reset = 1'b0;
      tick();

      // Main table: each run compared against its hand-computed record.
      for (int i = 0; i < 6; i++) begin
         run0(runs[i].w, runs[i].h, runs[i].base);
         check($sformatf("r%0d_npix", i), px_log0.size(), runs[i].n_pix);
         check($sformatf("r%0d_nrd", i),  rd_log0.size(), runs[i].n_pix * 3);
         if (runs[i].n_pix == 0) begin
            check($sformatf("r%0d_done_lat", i), done_cyc0 - acc0, 1);
            check($sformatf("r%0d_no_valid", i), seen_valid0, 0);
         end else if (px_log0.size() > 1 && rd_log0.size() > 0) begin
            cnt_hs = 0; cnt_vs = 0;
            foreach (hs_log0[k]) begin cnt_hs += hs_log0[k]; cnt_vs += vs_log0[k]; end
            check($sformatf("r%0d_first_addr", i), rd_log0[0], runs[i].base);
            check($sformatf("r%0d_last_addr", i), rd_log0[rd_log0.size()-1], runs[i].addr_last);
            check($sformatf("r%0d_pix_first", i), px_log0[0], runs[i].pix_first);
            check($sformatf("r%0d_pix_last", i), px_log0[px_log0.size()-1], runs[i].pix_last);
            check($sformatf("r%0d_sync_first", i), {hs_log0[0], vs_log0[0]}, 2'b11);
            check($sformatf("r%0d_n_hsync", i), cnt_hs, runs[i].n_hs);
            check($sformatf("r%0d_n_vsync", i), cnt_vs, 1);
            check($sformatf("r%0d_latency", i), first_valid0 - acc0, 5);
            check($sformatf("r%0d_interval", i), hs_cyc0[1] - hs_cyc0[0], 5);
            if (runs[i].h > 1 && rd_log0.size() > runs[i].w * 3)
               check($sformatf("r%0d_row1_addr", i), rd_log0[runs[i].w * 3], runs[i].addr_row1);
         end
         if (i == 0 && px_log0.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
               check($sformatf("r0_pix%0d_data", k), px_log0[k], pv[k].d);
               check($sformatf("r0_pix%0d_sync", k), {hs_log0[k], vs_log0[k]}, {pv[k].hs, pv[k].vs});
            end
         end
      end

      // Backpressure: output must freeze and no reads may be issued.
      if0.pix_ready = 1'b0;
      start0(2, 2, 20'h00100);
      for (int i = 0; i < 50 && !if0.pix_valid; i++) @(negedge clk);
      check("bp_valid_seen", if0.pix_valid, 1);
      cap_d = if0.pix_data; cap_hs = if0.hsync; cap_vs = if0.vsync;
      rd_snap = rd_log0.size();
      check("bp_first_data", cap_d, 24'h020100);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("bp_hold%0d", i), {if0.pix_valid, if0.hsync, if0.vsync, if0.pix_data},
               {1'b1, cap_hs, cap_vs, cap_d});
      end
      check("bp_no_rd", rd_log0.size(), rd_snap);
      tick();
      if0.pix_ready = 1'b1;
      wait_done0();
      check("bp_npix", px_log0.size(), 4);
      if (px_log0.size() == 4) check("bp_last", px_log0[3], R0_LAST);

      // Reset in PRESENT on the second pixel of row 0, with start raised alongside.
      start0(2, 2, 20'h00100);
      for (int i = 0; i < 50 && px_log0.size() == 0; i++) tick();
      if0.pix_ready = 1'b0;
      for (int i = 0; i < 50 && !if0.pix_valid; i++) @(negedge clk);
      check("mid_valid_col1", {if0.pix_valid, if0.pix_data}, {1'b1, 24'h050403});
      tick();
      reset = 1'b1; s0_start = 1'b1;
      tick();
      @(negedge clk);
      check("mid_rst_outputs", {if0.rd_en, if0.rd_addr, if0.pix_valid, if0.pix_data,
                                if0.hsync, if0.vsync, s0_busy, s0_done}, 0);
      tick();
      reset = 1'b0; s0_start = 1'b0;
      @(negedge clk);
      check("mid_rst_start_lost", s0_busy, 0);
      tick();
      if0.pix_ready = 1'b1;
      run0(2, 2, 20'h00100);
      check("restart_npix", px_log0.size(), 4);
      if (px_log0.size() == 4 && rd_log0.size() > 0) begin
         check("restart_addr", rd_log0[0], 20'h00100);
         check("restart_pix0", {vs_log0[0], px_log0[0]}, {1'b1, 24'h020100});
      end

      // Blanking instance: BPP=2, H_BLANK=4, V_BLANK=2, start while busy ignored.
      rd_log1.delete(); rd_cyc1.delete(); px_log1.delete(); hs_log1.delete();
      vs_log1.delete(); hs_cyc1.delete(); done_cnt1 = 0; seen_valid1 = 1'b0;
      s1_w = 12'd1; s1_h = 12'd2; s1_base = 20'h00040;
      s1_start = 1'b1; acc1 = cyc;
      tick();
      s1_start = 1'b0;
      repeat (7) tick();
      s1_w = 12'd3; s1_base = 20'h00080; s1_start = 1'b1;
      tick();
      s1_start = 1'b0;
      for (int i = 0; i < 200 && done_cnt1 == 0; i++) tick();
      repeat (6) tick();
      check("b_done_pulses", done_cnt1, 1);
      check("b_busy_idle", s1_busy, 0);
      check("b_nrd", rd_log1.size(), 4);
      check("b_npix", px_log1.size(), 2);
      if (px_log1.size() == 2 && rd_log1.size() == 4) begin
         check("b_latency", first_valid1 - acc1, 4);
         check("b_pix0", px_log1[0], 16'h4140);
         check("b_pix1", px_log1[1], B_PIX1);
         check("b_row1_addr", rd_log1[2], B_ROW1);
         check("b_sync", {hs_log1[0], vs_log1[0], hs_log1[1], vs_log1[1]}, 4'b1110);
         check("b_hblank_gap", rd_cyc1[2] - hs_cyc1[0], 5);
         check("b_vblank_done", done_cyc1 - hs_cyc1[1], 3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
